mem_access_stage: RTL and testbench

- Memory stage of the 5-stage RISC-V core, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives the data-memory bus through a req/gnt/rvalid handshake.
- Resolves branches using the registered ALU branch bit and jump target.
- Produces the MEM/WB pipeline register, and the MEM-stage forwarding and hazard signals.

---
 rtl/my_pkg.sv | 23 ++
 rtl/mem_access_stage_align.sv | 44 ++++
 rtl/mem_access_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types and constants for the memory-access stage of the RISC-V core.
package my_pkg;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
  } mem_ctrl_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane logic: store enables/data, misalignment and load extension.
module load_store_align
  import my_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        mis,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    mis       = 1'b0;
    load_data = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{lane_byte[7] & ~funct3[2]}}, lane_byte};
      end
      F3_H, F3_HU: begin
        mis       = addr_lo[0];
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{lane_half[15] & ~funct3[2]}}, lane_half};
      end
      default: begin
        mis = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM register, data-memory handshake FSM, branch resolution and MEM/WB register.
module mem_access_stage
  import my_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          flush,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [31:0]   ex_pc_jump,
  input  logic          ex_bit_branch,
  input  logic [4:0]    ex_rd,
  input  logic [2:0]    ex_funct3,
  input  mem_ctrl_t     ex_ctrl,
  output logic [DW-1:0] mem_alu_result,
  output logic [4:0]    mem_rd,
  output logic          mem_reg_write,
  output logic          pc_src,
  output logic [31:0]   pc_jump,
  output logic          stall,
  output logic          misalign,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [3:0]    dmem_be,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] wb_read_data,
  output logic [DW-1:0] wb_alu_result,
  output logic [4:0]    wb_rd,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg
);

  if (DW != 32) begin : g_dw_check
    $error("mem_access_stage: DW must be 32");
  end

  logic [31:0] alu_q, alu_d, sdata_q, sdata_d, pcj_q, pcj_d;
  logic        bb_q, bb_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  mem_ctrl_t   ctrl_q, ctrl_d;
  mem_state_e  state_q, state_d;

  logic [31:0] wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;

  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic        mis, op, acc_ok, done;

  load_store_align u_align (
    .funct3     (f3_q),
    .addr_lo    (alu_q[1:0]),
    .store_data (sdata_q),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .mis        (mis),
    .load_data  (load_data)
  );

  assign op     = ctrl_q.mem_read | ctrl_q.mem_write;
  assign acc_ok = op & ~mis;
  assign done   = (dmem_req & ctrl_q.mem_write & dmem_gnt)
                | ((state_q == WAIT_RSP) & dmem_rvalid);

  assign stall      = acc_ok & ~done;
  assign misalign   = op & mis;
  assign dmem_req   = (state_q == IDLE) & acc_ok;
  assign dmem_we    = (state_q == IDLE) & ctrl_q.mem_write;
  // Enables stay quiet unless a store is in MEM, so the bus is all-zero after reset.
  assign dmem_be    = ctrl_q.mem_write ? be : 4'b0000;
  assign dmem_addr  = {alu_q[AW-1:2], 2'b00};
  assign dmem_wdata = wdata;

  assign mem_alu_result = alu_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign pc_src         = ctrl_q.branch & bb_q;
  assign pc_jump        = pcj_q;

  assign wb_read_data  = wb_rdata_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_rw_q;
  assign wb_mem_to_reg = wb_m2r_q;

  always_comb begin
    alu_d      = alu_q;
    sdata_d    = sdata_q;
    pcj_d      = pcj_q;
    bb_d       = bb_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    ctrl_d     = ctrl_q;
    state_d    = state_q;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_m2r_d   = wb_m2r_q;
    if (EN) begin
      if (!stall) begin
        alu_d   = ex_alu_result;
        sdata_d = ex_store_data;
        pcj_d   = ex_pc_jump;
        bb_d    = ex_bit_branch;
        rd_d    = ex_rd;
        f3_d    = ex_funct3;
        ctrl_d  = flush ? '0 : ex_ctrl;
      end
      case (state_q)
        IDLE:
          if (dmem_req & ctrl_q.mem_read & ~ctrl_q.mem_write & dmem_gnt) state_d = WAIT_RSP;
        WAIT_RSP:
          if (dmem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (stall) begin
        wb_rdata_d = '0;
        wb_alu_d   = '0;
        wb_rd_d    = '0;
        wb_rw_d    = 1'b0;
        wb_m2r_d   = 1'b0;
      end else begin
        wb_rdata_d = load_data;
        wb_alu_d   = alu_q;
        wb_rd_d    = rd_q;
        wb_rw_d    = ctrl_q.reg_write & ~misalign;
        wb_m2r_d   = ctrl_q.mem_to_reg;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_q      <= '0;
      sdata_q    <= '0;
      pcj_q      <= '0;
      bb_q       <= 1'b0;
      rd_q       <= '0;
      f3_q       <= '0;
      ctrl_q     <= '0;
      state_q    <= IDLE;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
    end else begin
      alu_q      <= alu_d;
      sdata_q    <= sdata_d;
      pcj_q      <= pcj_d;
      bb_q       <= bb_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      ctrl_q     <= ctrl_d;
      state_q    <= state_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model plus directed literal checks.
module tb_mem_access_stage;
  import my_pkg::*;

  logic        CLK = 1'b0, RST = 1'b1, EN = 1'b1, flush = 1'b0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0, ex_pc_jump = '0;
  logic        ex_bit_branch = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  mem_ctrl_t   ex_ctrl = '0;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic [31:0] mem_alu_result, pc_jump, dmem_wdata, wb_read_data, wb_alu_result;
  logic [31:0] dmem_addr;
  logic [4:0]  mem_rd, wb_rd;
  logic [3:0]  dmem_be;
  logic        mem_reg_write, pc_src, stall, misalign, dmem_req, dmem_we;
  logic        wb_reg_write, wb_mem_to_reg;

  int n_chk = 0, n_fail = 0;

  mem_access_stage #(.AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .flush(flush),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_pc_jump(ex_pc_jump), .ex_bit_branch(ex_bit_branch), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_ctrl(ex_ctrl),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .pc_src(pc_src), .pc_jump(pc_jump), .stall(stall), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg)
  );

  always #5 CLK = ~CLK;

  // Model state: instruction sitting in MEM, whether its load is already granted, and the WB entry.
  typedef struct {
    logic [31:0] alu, sd, pcj;
    logic        bb;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, rw, m2r, br;
  } ins_t;

  ins_t        m_cur;
  logic        m_granted;
  logic [31:0] m_wb_alu, m_wb_rdata;
  logic [4:0]  m_wb_rd;
  logic        m_wb_rw, m_wb_m2r, m_wb_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = nbytes(f3);
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * int'(a))) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic is_mis(input ins_t c);
    return (int'(c.alu[1:0]) % nbytes(c.f3)) != 0;
  endfunction

  function automatic logic m_req();
    return (m_cur.mr | m_cur.mw) & ~is_mis(m_cur) & ~m_granted;
  endfunction

  function automatic logic m_stall();
    logic acc, dn;
    acc = (m_cur.mr | m_cur.mw) & ~is_mis(m_cur);
    dn  = (m_req() & m_cur.mw & dmem_gnt) | (m_granted & dmem_rvalid);
    return acc & ~dn;
  endfunction

  task automatic model_reset();
    m_cur = '{default: '0};
    m_granted = 1'b0;
    m_wb_alu = '0; m_wb_rdata = '0; m_wb_rd = '0;
    m_wb_rw = 1'b0; m_wb_m2r = 1'b0; m_wb_ld = 1'b0;
  endtask

  task automatic model_check();
    logic        op, mis, req;
    int          n;
    logic [31:0] wd;
    op  = m_cur.mr | m_cur.mw;
    mis = is_mis(m_cur);
    req = m_req();
    n   = nbytes(m_cur.f3);
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, req});
    chk("misalign", {31'd0, misalign}, {31'd0, op & mis});
    chk("pc_src", {31'd0, pc_src}, {31'd0, m_cur.br & m_cur.bb});
    chk("pc_jump", pc_jump, m_cur.pcj);
    chk("mem_alu_result", mem_alu_result, m_cur.alu);
    chk("mem_rd", {27'd0, mem_rd}, {27'd0, m_cur.rd});
    chk("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, m_cur.rw});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
    chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, m_wb_rw});
    chk("wb_mem_to_reg", {31'd0, wb_mem_to_reg}, {31'd0, m_wb_m2r});
    chk("wb_alu_result", wb_alu_result, m_wb_alu);
    if (m_wb_ld) chk("wb_read_data", wb_read_data, m_wb_rdata);
    if (req) begin
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_cur.mw});
      chk("dmem_addr", dmem_addr, m_cur.alu & ~32'd3);
      if (m_cur.mw) begin
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, 4'(((1 << n) - 1) << int'(m_cur.alu[1:0]))});
        if (n == 1)      wd = {24'd0, m_cur.sd[7:0]} * 32'h0101_0101;
        else if (n == 2) wd = {16'd0, m_cur.sd[15:0]} * 32'h0001_0001;
        else             wd = m_cur.sd;
        chk("dmem_wdata", dmem_wdata, wd);
      end
    end
  endtask

  task automatic model_update();
    logic op, mis, st, req;
    if (RST) begin
      model_reset();
      return;
    end
    if (!EN) return;
    op  = m_cur.mr | m_cur.mw;
    mis = is_mis(m_cur);
    st  = m_stall();
    req = m_req();
    if (st) begin
      m_wb_alu = '0; m_wb_rdata = '0; m_wb_rd = '0;
      m_wb_rw = 1'b0; m_wb_m2r = 1'b0; m_wb_ld = 1'b0;
    end else begin
      m_wb_alu   = m_cur.alu;
      m_wb_rd    = m_cur.rd;
      m_wb_rw    = m_cur.rw & ~(op & mis);
      m_wb_m2r   = m_cur.m2r;
      m_wb_ld    = m_cur.mr & ~m_cur.mw & ~mis;
      m_wb_rdata = ext(m_cur.f3, m_cur.alu[1:0], dmem_rdata);
    end
    if (m_granted && dmem_rvalid) m_granted = 1'b0;
    else if (req && m_cur.mr && !m_cur.mw && dmem_gnt) m_granted = 1'b1;
    if (!st) begin
      m_cur.alu = ex_alu_result; m_cur.sd = ex_store_data; m_cur.pcj = ex_pc_jump;
      m_cur.bb  = ex_bit_branch; m_cur.rd = ex_rd; m_cur.f3 = ex_funct3;
      m_cur.mr  = flush ? 1'b0 : ex_ctrl.mem_read;
      m_cur.mw  = flush ? 1'b0 : ex_ctrl.mem_write;
      m_cur.rw  = flush ? 1'b0 : ex_ctrl.reg_write;
      m_cur.m2r = flush ? 1'b0 : ex_ctrl.mem_to_reg;
      m_cur.br  = flush ? 1'b0 : ex_ctrl.branch;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic set_ex(input logic mr, mw, rw, br, bb, input logic [2:0] f3,
                        input logic [31:0] addr, sd, pcj, input logic [4:0] rd, input logic fl);
    ex_ctrl.mem_read = mr; ex_ctrl.mem_write = mw; ex_ctrl.reg_write = rw;
    ex_ctrl.mem_to_reg = mr; ex_ctrl.branch = br;
    ex_bit_branch = bb; ex_funct3 = f3; ex_alu_result = addr;
    ex_store_data = sd; ex_pc_jump = pcj; ex_rd = rd; flush = fl;
  endtask

  task automatic nop();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  logic [2:0] f3s [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

  initial begin
    model_reset();
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // SW 0x100 granted in the same cycle
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, F3_W, 32'h100, 32'hDEADBEEF, 32'd0, 5'd0, 1'b0);
    tick();
    nop(); dmem_gnt = 1'b1; #1;
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    tick(); dmem_gnt = 1'b0;

    // LB 0x103, gnt immediate, rvalid next cycle
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F3_B, 32'h103, 32'd0, 32'd0, 5'd5, 1'b0);
    tick();
    nop(); dmem_gnt = 1'b1; #1;
    chk("lb_stall_c0", {31'd0, stall}, 32'd1);
    tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_0000; #1;
    chk("lb_stall_c1", {31'd0, stall}, 32'd0);
    tick(); dmem_rvalid = 1'b0;
    chk("lb_wb_data", wb_read_data, 32'hFFFF_FF80);
    chk("lb_wb_rw", {31'd0, wb_reg_write}, 32'd1);

    // LHU 0x202 with grant delayed 3 cycles
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F3_HU, 32'h202, 32'd0, 32'd0, 5'd6, 1'b0);
    tick(); nop();
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3); #1;
      chk("lhu_stall", {31'd0, stall}, 32'd1);
      chk("lhu_req", {31'd0, dmem_req}, 32'd1);
      chk("lhu_addr", dmem_addr, 32'h200);
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD_0000; #1;
    chk("lhu_stall_end", {31'd0, stall}, 32'd0);
    tick(); dmem_rvalid = 1'b0;
    chk("lhu_wb_data", wb_read_data, 32'h0000_ABCD);

    // Misaligned LW 0x101
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F3_W, 32'h101, 32'd0, 32'd0, 5'd7, 1'b0);
    tick(); nop(); #1;
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("mis_flag_end", {31'd0, misalign}, 32'd0);

    // Branch taken, then the same with flush
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, F3_W, 32'd0, 32'd0, 32'h40, 5'd0, 1'b0);
    tick();
    chk("br_pc_src", {31'd0, pc_src}, 32'd1);
    chk("br_pc_jump", pc_jump, 32'h40);
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, F3_W, 32'd0, 32'd0, 32'h40, 5'd0, 1'b1);
    tick();
    chk("brfl_pc_src", {31'd0, pc_src}, 32'd0);
    chk("brfl_pc_jump", pc_jump, 32'h40);

    // EN=0 freezes the pipeline registers
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, F3_W, 32'd0, 32'd0, 32'h80, 5'd0, 1'b0);
    tick(); nop(); EN = 1'b0;
    tick();
    chk("en0_pc_src", {31'd0, pc_src}, 32'd1);
    chk("en0_pc_jump", pc_jump, 32'h80);
    EN = 1'b1;
    tick();
    chk("en1_pc_src", {31'd0, pc_src}, 32'd0);

    // Reset while waiting for read data; a late rvalid must be ignored
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, F3_W, 32'h300, 32'd0, 32'd0, 5'd9, 1'b0);
    tick(); nop(); dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    #2 RST = 1'b1; #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_mem_rw", {31'd0, mem_reg_write}, 32'd0);
    model_reset();
    RST = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick(); dmem_rvalid = 1'b0;
    chk("rst_late_rvalid_wb", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_late_req", {31'd0, dmem_req}, 32'd0);

    // Randomized traffic against the model with a randomly responding memory
    for (int c = 0; c < 1500; c++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      set_ex(kind < 4, (kind >= 4) && (kind < 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             f3s[$urandom_range(0, 4)], a, $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
      dmem_gnt    = m_req() ? ($urandom_range(0, 1) == 1) : 1'b0;
      dmem_rvalid = m_granted ? ($urandom_range(0, 1) == 1) : 1'b0;
      dmem_rdata  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
